// File: rtl/motoro3_pwm_multich_gen_if.sv
// Control/status bundle between the step/sequence logic (master) and the
// multi-channel PWM generator (slave).
interface motoro3_pwm_multich_gen_if #(
  parameter int NCH   = 3,
  parameter int CNT_W = 12,
  parameter int POS_W = 16
);
  logic                   pwmActive;
  logic                   frameStart;
  logic [CNT_W-1:0]       periodLen;
  logic [CNT_W-1:0]       minOn;
  logic [NCH*POS_W-1:0]   duty;
  logic [NCH-1:0]         pwm;
  logic                   periodTick;
  logic [NCH*POS_W-1:0]   lostAbs;

  modport master (
    output pwmActive, frameStart, periodLen, minOn, duty,
    input  pwm, periodTick, lostAbs
  );

  modport slave (
    input  pwmActive, frameStart, periodLen, minOn, duty,
    output pwm, periodTick, lostAbs
  );
endinterface

// File: rtl/motoro3_pwm_multich_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel
// left-aligned pulses with fractional remainder carry, runtime minimum
// on-time and clipping to the period. All state advances on the falling
// clock edge.
// Optional macro PWM_LOST_STAT_EN: per-channel |wanted - emitted| on-time
// statistics over each frame, reported on lostAbs; tied to 0 otherwise.
module motoro3_pwm_multich_gen #(
  parameter int NCH   = 3,
  parameter int CNT_W = 12,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    nRst,
  motoro3_pwm_multich_gen_if.slave bus_if
);

  localparam int EXT_W = (POS_W > CNT_W) ? POS_W : CNT_W;

  // Saturating unsigned add at POS_W+1 bits, clamped to 2^POS_W-1.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    logic [POS_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[POS_W] ? {POS_W{1'b1}} : s[POS_W-1:0];
  endfunction

  function automatic logic [EXT_W-1:0] min_ext(input logic [EXT_W-1:0] a,
                                               input logic [EXT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [CNT_W-1:0]            pcnt_q, pcnt_d;
  logic [NCH-1:0][CNT_W-1:0]   on_cnt_q, on_cnt_d;
  logic [NCH-1:0][POS_W-1:0]   remain_q, remain_d;
  logic                        activeD_q;
  logic                        tick_q, tick_d;

  logic                        bnd;
  logic                        clr_rem;
  logic [NCH-1:0][CNT_W-1:0]   on_new;
  logic [NCH-1:0][POS_W-1:0]   rem_new;
  logic [NCH-1:0]              pwm_w;

  // A boundary is the natural period end, a frame mark, or the first
  // active cycle after idle; the latter two also discard remainders.
  assign bnd     = bus_if.pwmActive &
                   ((pcnt_q == CNT_W'(1)) | bus_if.frameStart | ~activeD_q);
  assign clr_rem = bus_if.frameStart | ~activeD_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [POS_W-1:0] r;
    logic [POS_W-1:0] sum;
    logic [EXT_W-1:0] sum_x;
    logic [EXT_W-1:0] on_x;

    assign r     = clr_rem ? '0 : remain_q[k];
    assign sum   = sat_add(r, bus_if.duty[k*POS_W +: POS_W]);
    assign sum_x = EXT_W'(sum);
    // Below minOn the whole sum is deferred; otherwise clip to the period
    // and carry the excess into the next period.
    assign on_x  = (sum_x >= EXT_W'(bus_if.minOn)) ?
                   min_ext(sum_x, EXT_W'(bus_if.periodLen)) : '0;
    assign on_new[k]  = CNT_W'(on_x);
    assign rem_new[k] = sum - POS_W'(on_x);
    assign pwm_w[k]   = (on_cnt_q[k] != '0);
  end

  // Next-state for period counter, per-channel on-counters and remainders.
  always_comb begin
    pcnt_d   = pcnt_q;
    on_cnt_d = on_cnt_q;
    remain_d = remain_q;
    tick_d   = 1'b0;
    if (!bus_if.pwmActive) begin
      pcnt_d   = bus_if.periodLen;
      on_cnt_d = '0;
      remain_d = '0;
    end else if (bnd) begin
      pcnt_d   = bus_if.periodLen;
      tick_d   = 1'b1;
      on_cnt_d = on_new;
      remain_d = rem_new;
    end else begin
      pcnt_d = pcnt_q - CNT_W'(1);
      for (int k = 0; k < NCH; k++) begin
        if (on_cnt_q[k] != '0) begin
          on_cnt_d[k] = on_cnt_q[k] - CNT_W'(1);
        end
      end
    end
  end

  // Core state registers. The counter is reloaded from periodLen on the
  // first boundary after run enable, so a constant reset value is used to
  // keep the asynchronous reset path free of data inputs.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      pcnt_q    <= '0;
      on_cnt_q  <= '0;
      remain_q  <= '0;
      activeD_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      on_cnt_q  <= on_cnt_d;
      remain_q  <= remain_d;
      activeD_q <= bus_if.pwmActive;
      tick_q    <= tick_d;
    end
  end

  assign bus_if.pwm        = pwm_w;
  assign bus_if.periodTick = tick_q;

`ifdef PWM_LOST_STAT_EN
  logic [NCH-1:0][POS_W-1:0] want_q, want_d;
  logic [NCH-1:0][POS_W-1:0] real_q, real_d;
  logic [NCH-1:0][POS_W-1:0] lost_q, lost_d;
  logic [NCH-1:0][POS_W-1:0] real_inc;
  logic [NCH-1:0][POS_W-1:0] lost_new;

  for (genvar k = 0; k < NCH; k++) begin : g_stat
    // The current cycle's output still belongs to the frame being closed.
    assign real_inc[k] = sat_add(real_q[k], POS_W'(pwm_w[k]));
    assign lost_new[k] = (want_q[k] >= real_inc[k]) ? (want_q[k] - real_inc[k])
                                                    : (real_inc[k] - want_q[k]);
  end

  // Next-state for wanted/emitted accumulators and the per-frame result.
  always_comb begin
    want_d = want_q;
    real_d = real_q;
    lost_d = lost_q;
    if (!bus_if.pwmActive) begin
      want_d = '0;
      real_d = '0;
    end else begin
      real_d = real_inc;
      if (bnd) begin
        for (int k = 0; k < NCH; k++) begin
          want_d[k] = bus_if.frameStart ? bus_if.duty[k*POS_W +: POS_W]
                                        : sat_add(want_q[k], bus_if.duty[k*POS_W +: POS_W]);
        end
      end
      if (bus_if.frameStart) begin
        lost_d = lost_new;
        real_d = '0;
      end
    end
  end

  // Statistics registers.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      want_q <= '0;
      real_q <= '0;
      lost_q <= '0;
    end else begin
      want_q <= want_d;
      real_q <= real_d;
      lost_q <= lost_d;
    end
  end

  assign bus_if.lostAbs = lost_q;
`else
  assign bus_if.lostAbs = '0;
`endif

endmodule

// File: tb/tb_motoro3_pwm_multich_gen.sv
// Scoreboard bench for motoro3_pwm_multich_gen: the stimulus pushes one
// expected record per PWM period; a monitor measures each period (length,
// high cycles and leading high run per channel, lostAbs at period start)
// and compares against the popped record.
module tb_motoro3_pwm_multich_gen;

  localparam int NCH   = 3;
  localparam int CNT_W = 12;
  localparam int POS_W = 16;
`ifdef PWM_LOST_STAT_EN
  localparam bit LOSTEN = 1'b1;
`else
  localparam bit LOSTEN = 1'b0;
`endif

  logic clk;
  logic nRst;

  motoro3_pwm_multich_gen_if #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) dif ();

  motoro3_pwm_multich_gen #(.NCH(NCH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk    (clk),
    .nRst   (nRst),
    .bus_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int hi0, hi1, hi2;
    bit chk;
    int lo0, lo1, lo2;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // monitor state
  bit open = 1'b0;
  int len;
  int hi[NCH];
  int lead[NCH];
  bit run[NCH];
  int lo[NCH];

  task automatic push(input int l, input int h0, input int h1, input int h2,
                      input bit chk, input int e0, input int e1, input int e2);
    rec_t r;
    r.len = l; r.hi0 = h0; r.hi1 = h1; r.hi2 = h2;
    r.chk = chk;
    r.lo0 = LOSTEN ? e0 : 0;
    r.lo1 = LOSTEN ? e1 : 0;
    r.lo2 = LOSTEN ? e2 : 0;
    q.push_back(r);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!dif.periodTick && n < 400);
    if (!dif.periodTick) begin
      $display("FAIL wait_tick: periodTick=0 after 400 cycles, required 1");
      $fatal(1, "no period boundary");
    end
    #1;
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2);
    dif.duty = {16'(d2), 16'(d1), 16'(d0)};
  endtask

  task automatic close_rec();
    rec_t e;
    bit   ok;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL period: got len=%0d hi=%0d/%0d/%0d, required no period", len, hi[0], hi[1], hi[2]);
    end else begin
      e  = q.pop_front();
      ok = (len == e.len) &&
           (hi[0] == e.hi0) && (hi[1] == e.hi1) && (hi[2] == e.hi2) &&
           (lead[0] == e.hi0) && (lead[1] == e.hi1) && (lead[2] == e.hi2) &&
           (!e.chk || ((lo[0] == e.lo0) && (lo[1] == e.lo1) && (lo[2] == e.lo2)));
      if (!ok) begin
        bad++;
        $display("FAIL period: got len=%0d hi=%0d/%0d/%0d lead=%0d/%0d/%0d lost=%0d/%0d/%0d, required len=%0d hi=lead=%0d/%0d/%0d lost=%0d/%0d/%0d (checked=%0d)",
                 len, hi[0], hi[1], hi[2], lead[0], lead[1], lead[2], lo[0], lo[1], lo[2],
                 e.len, e.hi0, e.hi1, e.hi2, e.lo0, e.lo1, e.lo2, e.chk);
      end
    end
  endtask

  // Monitor: samples on the rising edge, away from the DUT's falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!nRst) begin
        open = 1'b0;
        total++;
        if (dif.pwm !== '0 || dif.periodTick !== 1'b0 || dif.lostAbs !== '0) begin
          bad++;
          $display("FAIL reset_state: pwm=%b tick=%b lostAbs=%h, required all zero",
                   dif.pwm, dif.periodTick, dif.lostAbs);
        end
      end else if (!dif.pwmActive) begin
        if (open) close_rec();
        open = 1'b0;
        total++;
        if (dif.pwm !== '0 || dif.periodTick !== 1'b0) begin
          bad++;
          $display("FAIL idle_state: pwm=%b tick=%b, required pwm=000 tick=0",
                   dif.pwm, dif.periodTick);
        end
      end else if (dif.periodTick) begin
        if (open) close_rec();
        open = 1'b1;
        len  = 1;
        for (int k = 0; k < NCH; k++) begin
          hi[k]   = int'(dif.pwm[k]);
          lead[k] = int'(dif.pwm[k]);
          run[k]  = dif.pwm[k];
          lo[k]   = int'(dif.lostAbs[k*POS_W +: POS_W]);
        end
      end else if (open) begin
        len++;
        for (int k = 0; k < NCH; k++) begin
          hi[k] += int'(dif.pwm[k]);
          if (run[k] && dif.pwm[k]) lead[k]++;
          else run[k] = 1'b0;
        end
      end
      if (done) begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL leftover: %0d expected periods never observed, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Stimulus: periodLen=100, minOn=20 unless changed below.
  initial begin
    nRst           = 1'b0;
    dif.pwmActive  = 1'b0;
    dif.frameStart = 1'b0;
    dif.periodLen  = 12'd100;
    dif.minOn      = 12'd20;
    set_duty(50, 0, 100);
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    cyc(4);

    // basic 50 / 0 / 100 pattern
    dif.pwmActive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(); push(100, 50, 0, 100, 0, 0, 0, 0);
    end
    set_duty(8, 0, 100);

    // fractional carry: 8, 16, 24 -> low, low, 24 high
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 24, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    // remain=16 here; mid-period frame mark clears it
    wait_tick(); push(41, 0, 0, 41, 0, 0, 0, 0);
    cyc(40); dif.frameStart = 1'b1;
    cyc(1);  dif.frameStart = 1'b0;
    push(100, 0, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 24, 0, 100, 0, 0, 0, 0);
    set_duty(130, 0, 100);

    // over-period duty: continuous high across boundaries
    wait_tick(); push(100, 100, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 100, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 100, 0, 100, 0, 0, 0, 0);
    set_duty(65535, 0, 100);
    // remainder saturates at 65535 instead of wrapping below minOn
    wait_tick(); push(100, 100, 0, 100, 0, 0, 0, 0);
    set_duty(101, 0, 100);
    wait_tick(); push(100, 100, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(11, 11, 0, 11, 0, 0, 0, 0);
    set_duty(50, 0, 100);
    cyc(10); dif.frameStart = 1'b1;
    cyc(1);  dif.frameStart = 1'b0;

    // run enable drops mid-pulse, then re-raises
    push(21, 21, 0, 21, 0, 0, 0, 0);
    cyc(20); dif.pwmActive = 1'b0;
    cyc(5);  dif.pwmActive = 1'b1;
    wait_tick(); push(100, 50, 0, 100, 0, 0, 0, 0);
    dif.minOn = 12'd1000;

    // minOn beyond periodLen: nothing emitted
    wait_tick(); push(100, 0, 0, 0, 0, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 0, 0, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 0, 0, 0, 0, 0);
    dif.minOn = 12'd20;
    set_duty(8, 0, 100);

    // frame mark coincident with period end: single boundary, lost stats
    cyc(99); dif.frameStart = 1'b1;
    cyc(1);  dif.frameStart = 1'b0;
    push(100, 0, 0, 100, 1, 150, 0, 300);
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    wait_tick(); push(100, 24, 0, 100, 0, 0, 0, 0);
    cyc(99); dif.frameStart = 1'b1;
    cyc(1);  dif.frameStart = 1'b0;
    push(100, 0, 0, 100, 1, 0, 0, 0);
    wait_tick(); push(100, 0, 0, 100, 0, 0, 0, 0);
    cyc(99); dif.frameStart = 1'b1;
    cyc(1);  dif.frameStart = 1'b0;
    push(100, 0, 0, 100, 1, 16, 0, 0);
    wait_tick();
    done = 1'b1;
  end

endmodule
